// File: rtl/mpe_seq_ctrl.sv
// Matrix-vector job sequencer for matrix_pe: walks NRAM/WRAM beat addresses row by row and collects results.
// Optional performance counters are built when MPE_SEQ_CTRL_PERF_EN is defined.
module mpe_seq_ctrl #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_nram_base,
  input  logic [ADDR_W-1:0] cmd_wram_base,
  input  logic [7:0]        cmd_len,
  input  logic [CNT_W-1:0]  cmd_num_out,
  output logic              nram_rd_en,
  output logic [ADDR_W-1:0] nram_rd_addr,
  output logic              wram_rd_en,
  output logic [ADDR_W-1:0] wram_rd_addr,
  input  logic              beat_ack,
  output logic [7:0]        mpe_uop,
  output logic              mpe_uop_valid,
  input  logic [31:0]       mpe_res,
  input  logic              mpe_res_vld,
  output logic [31:0]       res_data,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_idx,
  output logic              done,
  output logic              err,
  output logic [31:0]       perf_busy,
  output logic [31:0]       perf_stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_FIN
  } state_t;

  state_t            state_reg;
  logic              cmd_ready_reg;
  logic              rd_en_reg;
  logic              uop_valid_reg;
  logic [ADDR_W-1:0] nbase_reg;
  logic [ADDR_W-1:0] nptr_reg;
  logic [ADDR_W-1:0] wptr_reg;
  logic [7:0]        len_reg;
  logic [CNT_W-1:0]  num_reg;
  logic [7:0]        beat_reg;
  logic [CNT_W-1:0]  row_reg;
  logic [31:0]       res_data_reg;
  logic              res_valid_reg;
  logic [CNT_W-1:0]  res_idx_reg;
  logic              done_reg;
  logic              err_reg;

  logic last_beat;
  logic last_row;
  logic accept;

  assign last_beat = (beat_reg == (len_reg - 8'd1));
  assign last_row  = (row_reg == (num_reg - CNT_W'(1)));
  assign accept    = (state_reg == S_IDLE) && cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cmd_ready_reg <= 1'b1;
      rd_en_reg     <= 1'b0;
      uop_valid_reg <= 1'b0;
      nbase_reg     <= '0;
      nptr_reg      <= '0;
      wptr_reg      <= '0;
      len_reg       <= '0;
      num_reg       <= '0;
      beat_reg      <= '0;
      row_reg       <= '0;
      res_data_reg  <= '0;
      res_valid_reg <= 1'b0;
      res_idx_reg   <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      res_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            nbase_reg     <= cmd_nram_base;
            nptr_reg      <= cmd_nram_base;
            wptr_reg      <= cmd_wram_base;
            len_reg       <= cmd_len;
            num_reg       <= cmd_num_out;
            beat_reg      <= '0;
            row_reg       <= '0;
            cmd_ready_reg <= 1'b0;
            if ((cmd_len == 8'd0) || (cmd_num_out == '0)) begin
              err_reg   <= 1'b1;
              state_reg <= S_FIN;
            end else begin
              err_reg       <= 1'b0;
              rd_en_reg     <= 1'b1;
              uop_valid_reg <= 1'b1;
              state_reg     <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (beat_ack) begin
            // Weights are row-major, so wptr keeps counting across rows.
            wptr_reg <= wptr_reg + ADDR_W'(1);
            if (last_beat) begin
              nptr_reg <= nbase_reg;
              beat_reg <= '0;
              if (mpe_res_vld) begin
                // Zero-latency result for this row: capture it and skip WAIT.
                res_data_reg  <= mpe_res;
                res_idx_reg   <= row_reg;
                res_valid_reg <= 1'b1;
                if (last_row) begin
                  rd_en_reg     <= 1'b0;
                  uop_valid_reg <= 1'b0;
                  done_reg      <= 1'b1;
                  state_reg     <= S_FIN;
                end else begin
                  row_reg <= row_reg + CNT_W'(1);
                end
              end else begin
                rd_en_reg     <= 1'b0;
                uop_valid_reg <= 1'b0;
                state_reg     <= S_WAIT;
              end
            end else begin
              beat_reg <= beat_reg + 8'd1;
              nptr_reg <= nptr_reg + ADDR_W'(1);
            end
          end
        end

        S_WAIT: begin
          if (mpe_res_vld) begin
            res_data_reg  <= mpe_res;
            res_idx_reg   <= row_reg;
            res_valid_reg <= 1'b1;
            if (last_row) begin
              done_reg  <= 1'b1;
              state_reg <= S_FIN;
            end else begin
              row_reg       <= row_reg + CNT_W'(1);
              beat_reg      <= '0;
              rd_en_reg     <= 1'b1;
              uop_valid_reg <= 1'b1;
              state_reg     <= S_RUN;
            end
          end
        end

        S_FIN: begin
          // Normal jobs enter with done already set; illegal commands raise it here.
          if (done_reg) begin
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end else begin
            done_reg <= 1'b1;
          end
        end

        default: begin
          state_reg     <= S_IDLE;
          cmd_ready_reg <= 1'b1;
          rd_en_reg     <= 1'b0;
          uop_valid_reg <= 1'b0;
          done_reg      <= 1'b0;
          err_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_reg;
  assign nram_rd_en    = rd_en_reg;
  assign wram_rd_en    = rd_en_reg;
  assign nram_rd_addr  = nptr_reg;
  assign wram_rd_addr  = wptr_reg;
  assign mpe_uop       = len_reg;
  assign mpe_uop_valid = uop_valid_reg;
  assign res_data      = res_data_reg;
  assign res_valid     = res_valid_reg;
  assign res_idx       = res_idx_reg;
  assign done          = done_reg;
  assign err           = err_reg;

`ifdef MPE_SEQ_CTRL_PERF_EN
  logic [31:0] busy_reg;
  logic [31:0] stall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg  <= '0;
      stall_reg <= '0;
    end else if (accept) begin
      busy_reg  <= '0;
      stall_reg <= '0;
    end else begin
      if ((state_reg != S_IDLE) && (busy_reg != 32'hFFFF_FFFF)) begin
        busy_reg <= busy_reg + 32'd1;
      end
      if ((state_reg == S_RUN) && rd_en_reg && !beat_ack && (stall_reg != 32'hFFFF_FFFF)) begin
        stall_reg <= stall_reg + 32'd1;
      end
    end
  end

  assign perf_busy  = busy_reg;
  assign perf_stall = stall_reg;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign perf_busy     = 32'd0;
  assign perf_stall    = 32'd0;
`endif

endmodule

// File: tb/tb_mpe_seq_ctrl.sv
// Directed testbench for mpe_seq_ctrl with a small behavioural matrix_pe responder.
module tb_mpe_seq_ctrl;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_nram_base;
  logic [ADDR_W-1:0] cmd_wram_base;
  logic [7:0]        cmd_len;
  logic [CNT_W-1:0]  cmd_num_out;
  logic              nram_rd_en;
  logic [ADDR_W-1:0] nram_rd_addr;
  logic              wram_rd_en;
  logic [ADDR_W-1:0] wram_rd_addr;
  logic              beat_ack;
  logic [7:0]        mpe_uop;
  logic              mpe_uop_valid;
  logic [31:0]       mpe_res;
  logic              mpe_res_vld;
  logic [31:0]       res_data;
  logic              res_valid;
  logic [CNT_W-1:0]  res_idx;
  logic              done;
  logic              err;
  logic [31:0]       perf_busy;
  logic [31:0]       perf_stall;

  always #5 clk = ~clk;

  mpe_seq_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_nram_base(cmd_nram_base), .cmd_wram_base(cmd_wram_base),
    .cmd_len(cmd_len), .cmd_num_out(cmd_num_out),
    .nram_rd_en(nram_rd_en), .nram_rd_addr(nram_rd_addr),
    .wram_rd_en(wram_rd_en), .wram_rd_addr(wram_rd_addr),
    .beat_ack(beat_ack), .mpe_uop(mpe_uop), .mpe_uop_valid(mpe_uop_valid),
    .mpe_res(mpe_res), .mpe_res_vld(mpe_res_vld),
    .res_data(res_data), .res_valid(res_valid), .res_idx(res_idx),
    .done(done), .err(err), .perf_busy(perf_busy), .perf_stall(perf_stall)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [ADDR_W-1:0] nq[$];
  logic [ADDR_W-1:0] wq[$];
  logic [ADDR_W-1:0] rdq[$];
  logic [CNT_W-1:0]  idxq[$];
  logic [31:0]       dataq[$];
  int          done_cnt, done_cyc, first_rd_cyc;
  logic        done_err, done_with_res, cmd_ready_at_done, cmd_ready_after;
  logic        uop_ok;
  logic        timed_out, aborted;
  logic [31:0] busy_after, stall_after;

  // Issues one command and plays matrix_pe; records observations only.
  task automatic run_job(input logic [ADDR_W-1:0] nb, input logic [ADDR_W-1:0] wb,
                         input logic [7:0] len, input logic [CNT_W-1:0] num,
                         input int ack_mode, input int lat, input int rst_row, input int max_cyc);
    int beat_in_row;
    int rows_sent;
    int cd;
    int rd_cycles;
    logic ack;
    beat_in_row = 0; rows_sent = 0; cd = -1; rd_cycles = 0;
    nq.delete(); wq.delete(); rdq.delete(); idxq.delete(); dataq.delete();
    done_cnt = 0; done_cyc = -10; first_rd_cyc = -1;
    done_err = 1'b0; done_with_res = 1'b0; cmd_ready_at_done = 1'b1; cmd_ready_after = 1'b0;
    uop_ok = 1'b1; timed_out = 1'b0; aborted = 1'b0; busy_after = '0; stall_after = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_nram_base = nb; cmd_wram_base = wb; cmd_len = len; cmd_num_out = num;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (res_valid) begin
        idxq.push_back(res_idx);
        dataq.push_back(res_data);
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
        done_err = err;
        done_with_res = res_valid;
        cmd_ready_at_done = cmd_ready;
      end
      if (done_cnt > 0 && c == done_cyc + 1) begin
        cmd_ready_after = cmd_ready;
        busy_after = perf_busy;
        stall_after = perf_stall;
      end
      if (done_cnt > 0 && c >= done_cyc + 3) break;
      if (rst_row >= 0 && nram_rd_en && idxq.size() == rst_row) begin
        rst_n = 1'b0;
        beat_ack = 1'b0;
        mpe_res_vld = 1'b0;
        aborted = 1'b1;
        return;
      end
      mpe_res_vld = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mpe_res_vld = 1'b1;
          mpe_res = 32'hC0DE_0000 + rows_sent;
          rows_sent++;
          cd = -1;
        end
      end
      ack = (ack_mode == 0) ? 1'b1 : ((rd_cycles % 2) == 0);
      beat_ack = ack;
      if (nram_rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = c;
        if (!wram_rd_en || !mpe_uop_valid || mpe_uop !== len) uop_ok = 1'b0;
        rdq.push_back(nram_rd_addr);
        rd_cycles++;
        if (ack) begin
          nq.push_back(nram_rd_addr);
          wq.push_back(wram_rd_addr);
          beat_in_row++;
          if (beat_in_row == len) begin
            beat_in_row = 0;
            if (lat == 0) begin
              mpe_res_vld = 1'b1;
              mpe_res = 32'hC0DE_0000 + rows_sent;
              rows_sent++;
            end else begin
              cd = lat;
            end
          end
        end
      end
      @(negedge clk);
    end
    timed_out = (done_cnt == 0);
    beat_ack = 1'b0;
    mpe_res_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    assert_cnt++;
    if ({cmd_ready, nram_rd_en, wram_rd_en, mpe_uop_valid, res_valid, done, err} !== 7'b1000000) begin
      fail_cnt++; $display("FAIL reset_ctrl: got %b want 1000000",
        {cmd_ready, nram_rd_en, wram_rd_en, mpe_uop_valid, res_valid, done, err});
    end
    rst_n = 1'b1;
    @(negedge clk);
    assert_cnt++;
    if ({nram_rd_addr, wram_rd_addr, mpe_uop, res_data, res_idx, perf_busy, perf_stall} !== '0) begin
      fail_cnt++; $display("FAIL reset_data: nonzero datapath after reset addr=%h/%h uop=%h", nram_rd_addr, wram_rd_addr, mpe_uop);
    end
    assert_cnt++;
    if (cmd_ready !== 1'b1) begin
      fail_cnt++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    run_job(12'h010, 12'h100, 8'd4, 16'd2, 0, 5, -1, 200);
    assert_cnt++;
    if (timed_out) begin fail_cnt++; $display("FAIL t1_timeout: no done within budget"); end
    assert_cnt++;
    if (first_rd_cyc !== 1) begin fail_cnt++; $display("FAIL t1_first_rd: got %0d want 1", first_rd_cyc); end
    assert_cnt++;
    if (nq.size() !== 8 || wq.size() !== 8) begin
      fail_cnt++; $display("FAIL t1_beats: got %0d/%0d want 8/8", nq.size(), wq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        assert_cnt++;
        if (nq[i] !== 12'h010 + 12'(i % 4) || wq[i] !== 12'h100 + 12'(i)) begin
          fail_cnt++; $display("FAIL t1_addr[%0d]: got n=%h w=%h want n=%h w=%h", i, nq[i], wq[i],
            12'h010 + 12'(i % 4), 12'h100 + 12'(i));
        end
      end
    end
    assert_cnt++;
    if (!uop_ok) begin fail_cnt++; $display("FAIL t1_uop: uop/uop_valid/wram_rd_en wrong during RUN"); end
    assert_cnt++;
    if (idxq.size() !== 2) begin
      fail_cnt++; $display("FAIL t1_res_count: got %0d want 2", idxq.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        assert_cnt++;
        if (idxq[i] !== 16'(i) || dataq[i] !== 32'hC0DE_0000 + i) begin
          fail_cnt++; $display("FAIL t1_res[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i, idxq[i], dataq[i], i, 32'hC0DE_0000 + i);
        end
      end
    end
    assert_cnt++;
    if (done_cnt !== 1 || done_err !== 1'b0 || done_with_res !== 1'b1) begin
      fail_cnt++; $display("FAIL t1_done: got cnt=%0d err=%b with_res=%b want 1/0/1", done_cnt, done_err, done_with_res);
    end
    assert_cnt++;
    if (cmd_ready_at_done !== 1'b0 || cmd_ready_after !== 1'b1) begin
      fail_cnt++; $display("FAIL t1_ready: got at_done=%b after=%b want 0/1", cmd_ready_at_done, cmd_ready_after);
    end
    $display("test_basic done: beats=%0d results=%0d", nq.size(), idxq.size());
  endtask

  task automatic test_illegal();
    run_job(12'h020, 12'h200, 8'd0, 16'd3, 0, 1, -1, 50);
    assert_cnt++;
    if (first_rd_cyc !== -1) begin fail_cnt++; $display("FAIL t2_no_rd: rd_en seen at cycle %0d want none", first_rd_cyc); end
    assert_cnt++;
    if (done_cyc !== 2 || done_err !== 1'b1 || done_cnt !== 1) begin
      fail_cnt++; $display("FAIL t2_done: got cyc=%0d err=%b cnt=%0d want 2/1/1", done_cyc, done_err, done_cnt);
    end
    assert_cnt++;
    if (cmd_ready_after !== 1'b1 || idxq.size() !== 0) begin
      fail_cnt++; $display("FAIL t2_ready: got ready_after=%b res=%0d want 1/0", cmd_ready_after, idxq.size());
    end
    run_job(12'h020, 12'h200, 8'd2, 16'd0, 0, 1, -1, 50);
    assert_cnt++;
    if (first_rd_cyc !== -1 || done_err !== 1'b1 || done_cyc !== 2) begin
      fail_cnt++; $display("FAIL t2_num0: got rd=%0d err=%b cyc=%0d want -1/1/2", first_rd_cyc, done_err, done_cyc);
    end
    $display("test_illegal done");
  endtask

  task automatic test_stall();
    logic [31:0] exp_busy;
    logic [31:0] exp_stall;
    logic [ADDR_W-1:0] exp_rd[5];
`ifdef MPE_SEQ_CTRL_PERF_EN
    exp_busy = 32'd8; exp_stall = 32'd2;
`else
    exp_busy = 32'd0; exp_stall = 32'd0;
`endif
    exp_rd[0] = 12'h030; exp_rd[1] = 12'h031; exp_rd[2] = 12'h031; exp_rd[3] = 12'h032; exp_rd[4] = 12'h032;
    run_job(12'h030, 12'h300, 8'd3, 16'd1, 1, 2, -1, 100);
    assert_cnt++;
    if (rdq.size() !== 5) begin
      fail_cnt++; $display("FAIL t3_rd_cycles: got %0d want 5", rdq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        assert_cnt++;
        if (rdq[i] !== exp_rd[i]) begin
          fail_cnt++; $display("FAIL t3_hold[%0d]: got %h want %h", i, rdq[i], exp_rd[i]);
        end
      end
    end
    assert_cnt++;
    if (stall_after !== exp_stall) begin fail_cnt++; $display("FAIL t3_perf_stall: got %0d want %0d", stall_after, exp_stall); end
    assert_cnt++;
    if (busy_after !== exp_busy) begin fail_cnt++; $display("FAIL t3_perf_busy: got %0d want %0d", busy_after, exp_busy); end
    assert_cnt++;
    if (done_cnt !== 1 || idxq.size() !== 1) begin
      fail_cnt++; $display("FAIL t3_done: got done=%0d res=%0d want 1/1", done_cnt, idxq.size());
    end
    $display("test_stall done: stall=%0d busy=%0d", stall_after, busy_after);
  endtask

  task automatic test_back_to_back();
    run_job(12'h040, 12'h400, 8'd1, 16'd3, 0, 0, -1, 50);
    assert_cnt++;
    if (idxq.size() !== 3) begin
      fail_cnt++; $display("FAIL t4_res_count: got %0d want 3", idxq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        assert_cnt++;
        if (idxq[i] !== 16'(i) || dataq[i] !== 32'hC0DE_0000 + i) begin
          fail_cnt++; $display("FAIL t4_res[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i, idxq[i], dataq[i], i, 32'hC0DE_0000 + i);
        end
      end
    end
    assert_cnt++;
    if (done_cnt !== 1 || done_with_res !== 1'b1 || done_cyc !== 4) begin
      fail_cnt++; $display("FAIL t4_done: got cnt=%0d with_res=%b cyc=%0d want 1/1/4", done_cnt, done_with_res, done_cyc);
    end
    $display("test_back_to_back done: results=%0d", idxq.size());
  endtask

  task automatic test_reset_mid_job();
    logic seen;
    run_job(12'h050, 12'h500, 8'd2, 16'd4, 0, 1, 1, 100);
    assert_cnt++;
    if (!aborted) begin fail_cnt++; $display("FAIL t5_reach_row1: row 1 RUN never reached"); end
    #1;
    assert_cnt++;
    if ({cmd_ready, nram_rd_en, wram_rd_en, mpe_uop_valid, res_valid, done, err} !== 7'b1000000 ||
        {nram_rd_addr, wram_rd_addr, mpe_uop, res_data, res_idx} !== '0) begin
      fail_cnt++; $display("FAIL t5_async_reset: got ctrl=%b addr=%h/%h want 1000000 and zero data",
        {cmd_ready, nram_rd_en, wram_rd_en, mpe_uop_valid, res_valid, done, err}, nram_rd_addr, wram_rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mpe_res_vld = 1'b1; mpe_res = 32'hDEAD_BEEF; beat_ack = 1'b1;
    @(negedge clk);
    mpe_res_vld = 1'b0; beat_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (res_valid || done || nram_rd_en) seen = 1'b1;
      @(negedge clk);
    end
    assert_cnt++;
    if (seen) begin fail_cnt++; $display("FAIL t5_late_res: activity after reset got 1 want 0"); end
    run_job(12'h060, 12'h600, 8'd2, 16'd2, 0, 1, -1, 100);
    assert_cnt++;
    if (nq.size() !== 4 || nq[0] !== 12'h060 || nq[3] !== 12'h061 || wq[3] !== 12'h603) begin
      fail_cnt++; $display("FAIL t5_rerun_addr: got beats=%0d", nq.size());
    end
    assert_cnt++;
    if (idxq.size() !== 2 || idxq[0] !== 16'd0 || idxq[1] !== 16'd1 || dataq[0] !== 32'hC0DE_0000 || done_cnt !== 1 || done_err !== 1'b0) begin
      fail_cnt++; $display("FAIL t5_rerun_res: got res=%0d done=%0d err=%b want 2/1/0", idxq.size(), done_cnt, done_err);
    end
    $display("test_reset_mid_job done");
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_n[4];
    logic [ADDR_W-1:0] exp_w[4];
    exp_n[0] = 12'hFFE; exp_n[1] = 12'hFFF; exp_n[2] = 12'h000; exp_n[3] = 12'h001;
    exp_w[0] = 12'hFFD; exp_w[1] = 12'hFFE; exp_w[2] = 12'hFFF; exp_w[3] = 12'h000;
    run_job(12'hFFE, 12'hFFD, 8'd4, 16'd1, 0, 3, -1, 100);
    assert_cnt++;
    if (nq.size() !== 4) begin
      fail_cnt++; $display("FAIL t6_beats: got %0d want 4", nq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        assert_cnt++;
        if (nq[i] !== exp_n[i] || wq[i] !== exp_w[i]) begin
          fail_cnt++; $display("FAIL t6_wrap[%0d]: got n=%h w=%h want n=%h w=%h", i, nq[i], wq[i], exp_n[i], exp_w[i]);
        end
      end
    end
    assert_cnt++;
    if (done_cnt !== 1 || done_err !== 1'b0) begin
      fail_cnt++; $display("FAIL t6_done: got cnt=%0d err=%b want 1/0", done_cnt, done_err);
    end
    $display("test_wrap done");
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_nram_base = '0; cmd_wram_base = '0; cmd_len = '0; cmd_num_out = '0;
    beat_ack = 1'b0; mpe_res = '0; mpe_res_vld = 1'b0;
    test_reset();
    test_basic();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_reset_mid_job();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
